// File: rtl/divider_8_bit.sv
// divider_8_bit
// Unsigned 8-bit by 8-bit restoring divider. Each accepted request takes
// eight iteration cycles, with one quotient bit resolved per cycle. A zero
// divisor skips the iterations and produces a flagged result immediately.
//
// Ports:
//   clk         - rising-edge clock for all state
//   reset_n     - asynchronous active-low reset
//   start       - request a division; only looked at while idle
//   dividend    - unsigned dividend, captured when the request is accepted
//   divisor     - unsigned divisor, captured when the request is accepted
//   quotient    - quotient of the last completed operation
//   remainder   - remainder of the last completed operation
//   busy        - high while an operation is running or completing
//   done        - one-cycle pulse when a new result is presented
//   div_by_zero - high when the last accepted divisor was zero

module divider_8_bit (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;

    logic [8:0] acc_a;
    logic [7:0] acc_q;
    logic [7:0] div_d;
    logic [2:0] iter_cnt;

    logic [8:0] shift_s;
    logic [8:0] sub_b;
    logic [8:0] sub_t;
    logic [9:0] carry;
    logic       sub_ok;
    logic [8:0] step_a;
    logic [7:0] step_q;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. The eighth iteration is the one taken while the
    // counter already holds 7, so that same edge moves on to DONE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (divisor == 8'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (iter_cnt == 3'd7) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One restoring step. S - D is formed as S + ~D + 1 with an explicit
    // 9-bit ripple chain. A carry out of the top bit means S >= D, so the
    // subtraction is kept and a 1 enters the quotient.
    always_comb begin
        shift_s  = {acc_a[7:0], acc_q[7]};
        sub_b    = ~{1'b0, div_d};
        sub_t    = '0;
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            sub_t[i]     = shift_s[i] ^ sub_b[i] ^ carry[i];
            carry[i + 1] = (shift_s[i] & sub_b[i]) |
                           (carry[i] & (shift_s[i] ^ sub_b[i]));
        end
        sub_ok = carry[9];
        step_a = sub_ok ? sub_t : shift_s;
        step_q = {acc_q[6:0], sub_ok};
    end

    // Datapath and output registers. busy and done are decoded from the
    // next state so both are plain flops with no path from the inputs.
    // quotient/remainder are loaded only on the edge that enters DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_a       <= '0;
            acc_q       <= '0;
            div_d       <= '0;
            iter_cnt    <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= (next_state != IDLE);
            done <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_a       <= '0;
                        acc_q       <= dividend;
                        div_d       <= divisor;
                        iter_cnt    <= '0;
                        div_by_zero <= (divisor == 8'd0);
                        if (divisor == 8'd0) begin
                            quotient  <= 8'hFF;
                            remainder <= dividend;
                        end
                    end
                end
                RUN: begin
                    acc_a    <= step_a;
                    acc_q    <= step_q;
                    iter_cnt <= iter_cnt + 3'd1;
                    if (iter_cnt == 3'd7) begin
                        quotient  <= step_q;
                        remainder <= step_a[7:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
